// File: rtl/ram_seq_master.sv
// ram_seq_master: LOAD streams s_* words into a single-port RAM, DUMP streams RAM words to m_*; RAM_SEQ_CHECKSUM_EN adds a running word sum.
// Latency: LOAD writes in the cycle a word is accepted; DUMP shows its first m_valid two edges after the accept edge, then 1 word/cycle.
// Backpressure: s_ready is high only in LOAD; m_ready stalls DUMP through a 2-entry output FIFO that throttles read issue.
module ram_seq_master #(
    parameter int MEM_DEPTH = 256,
    parameter int MEM_WIDTH = 32,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [AW-1:0]        cmd_base,
    input  logic [AW:0]          cmd_len,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [MEM_WIDTH-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [MEM_WIDTH-1:0] m_data,
    output logic                 done,
    output logic                 busy,
    output logic [AW-1:0]        ram_address,
    output logic [MEM_WIDTH-1:0] ram_write_data,
    output logic                 ram_write_en,
    input  logic [MEM_WIDTH-1:0] ram_read_data
`ifdef RAM_SEQ_CHECKSUM_EN
    ,
    output logic [MEM_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, DUMP, FINISH} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    state_t               state, state_next;
    logic [AW-1:0]        addr, addr_inc, addr_hold;
    logic [AW:0]          remaining;
    logic                 inflight;
    logic [MEM_WIDTH-1:0] fifo_mem [2];
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           fifo_cnt, cnt_after;
    logic                 accept, wr, issue, push, pop;

    assign accept   = (state == IDLE) && cmd_valid;
    assign wr       = !reset && (state == LOAD) && s_valid;
    assign push     = (state == DUMP) && inflight;
    assign pop      = m_valid && m_ready;
    assign addr_inc = (addr == LAST_ADDR) ? '0 : addr + AW'(1);

    // Occupancy at the start of next cycle; a pop this cycle frees the slot the new read will land in.
    assign cnt_after = fifo_cnt + {1'b0, push} - {1'b0, pop};
    assign issue     = !reset && (state == DUMP) && (remaining != '0) && (cnt_after < 2'd2);

    assign cmd_ready      = !reset && (state == IDLE);
    assign busy           = !reset && (state != IDLE);
    assign done           = !reset && (state == FINISH);
    assign s_ready        = !reset && (state == LOAD);
    assign m_valid        = !reset && (fifo_cnt != 2'd0);
    assign m_data         = reset ? '0 : fifo_mem[rd_ptr];
    assign ram_write_en   = wr;
    assign ram_write_data = wr ? s_data : '0;
    assign ram_address    = reset ? '0 : ((wr || issue) ? addr : addr_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_next = FINISH;
                    end else if (cmd_write) begin
                        state_next = LOAD;
                    end else begin
                        state_next = DUMP;
                    end
                end
            end
            LOAD: begin
                if (wr && (remaining == {{AW{1'b0}}, 1'b1})) begin
                    state_next = FINISH;
                end
            end
            DUMP: begin
                if ((remaining == '0) && !inflight && (cnt_after == 2'd0)) begin
                    state_next = FINISH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            addr_hold <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fifo_cnt  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            inflight <= issue;
            fifo_cnt <= cnt_after;
            if (accept) begin
                addr      <= cmd_base;
                remaining <= cmd_len;
            end else if (wr || issue) begin
                addr      <= addr_inc;
                addr_hold <= addr;
                remaining <= remaining - {{AW{1'b0}}, 1'b1};
            end
            if (push) begin
                fifo_mem[wr_ptr] <= ram_read_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

`ifdef RAM_SEQ_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            checksum <= '0;
        end else if (wr) begin
            checksum <= checksum + s_data;
        end else if (pop) begin
            checksum <= checksum + m_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_seq_master.sv
// tb_ram_seq_master: directed LOAD/DUMP/len=0/reset/wrap sequences against ram_seq_master with a behavioural RAM.
// Latency: checks write timing, first-m_valid latency and done position against hand-computed cycle numbers.
// Backpressure: drives m_ready patterns and confirms every word appears once, in order.
module tb_ram_seq_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_base = '0;
    logic [8:0]  cmd_len = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        done;
    logic        busy;
    logic [7:0]  ram_address;
    logic [31:0] ram_write_data;
    logic        ram_write_en;
    logic [31:0] ram_read_data = '0;
`ifdef RAM_SEQ_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_mem [256];

    always #5 clk = ~clk;

    ram_seq_master dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_base       (cmd_base),
        .cmd_len        (cmd_len),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .done           (done),
        .busy           (busy),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_write_en   (ram_write_en),
        .ram_read_data  (ram_read_data)
`ifdef RAM_SEQ_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always @(posedge clk) begin
        if (ram_write_en) begin
            ram_mem[ram_address] <= ram_write_data;
        end
        ram_read_data <= ram_mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Words first, first+1, ... written from base upward; s_valid drops for one cycle at step 'gap'.
    task automatic do_load(input logic [7:0] base, input logic [8:0] len,
                           input logic [31:0] first, input int gap);
        int i = 0;
        int t = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = base; cmd_len = len;
        s_valid = 1'b1; s_data = first;
        #1 chk("load_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (i < int'(len) && t < 600) begin
            s_valid = (t != gap);
            s_data  = first + i;
            #1;
            chk("load_s_ready", s_ready, 1);
            chk("load_busy", busy, 1);
            if (s_valid) begin
                chk("load_wen", ram_write_en, 1);
                chk("load_addr", ram_address, (int'(base) + i) % 256);
                chk("load_wdata", ram_write_data, first + i);
                i++;
            end else begin
                chk("load_gap_wen", ram_write_en, 0);
            end
            @(negedge clk);
            t++;
        end
        s_valid = 1'b0;
        #1;
        chk("load_done", done, 1);
        chk("load_done_wen", ram_write_en, 0);
        @(negedge clk);
        #1;
        chk("load_idle_done", done, 0);
        chk("load_idle_ready", cmd_ready, 1);
        chk("load_idle_busy", busy, 0);
    endtask

    // m_ready follows pat[t%4]; exp_done_t < 0 skips the done-position check.
    task automatic do_dump(input logic [7:0] base, input logic [8:0] len, input logic [31:0] first,
                           input logic [3:0] pat, input int exp_done_t);
        int i = 0;
        int t = 0;
        bit got_done = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = base; cmd_len = len; m_ready = 1'b0;
        #1 chk("dump_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!got_done && t < 1000) begin
            m_ready = pat[t % 4];
            #1;
            if (t < 2) chk("dump_early_valid", m_valid, 0);
            if (t == 2) chk("dump_first_valid", m_valid, 1);
            chk("dump_wen", ram_write_en, 0);
            if (done) begin
                got_done = 1'b1;
                chk("dump_count", i, int'(len));
                chk("dump_done_valid", m_valid, 0);
                if (exp_done_t >= 0) chk("dump_done_cycle", t, exp_done_t);
            end else if (m_valid && m_ready) begin
                chk("dump_data", m_data, first + i);
                i++;
            end
            @(negedge clk);
            t++;
        end
        chk("dump_done_seen", got_done, 1);
        m_ready = 1'b0;
        #1;
        chk("dump_idle_ready", cmd_ready, 1);
        chk("dump_idle_done", done, 0);
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wen", ram_write_en, 0);
        chk("rst_done", done, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_addr", ram_address, 0);
        chk("post_rst_wdata", ram_write_data, 0);
        chk("post_rst_m_data", m_data, 0);

        do_load(8'd4, 9'd3, 32'hA, -1);
        chk("idle_addr_hold", ram_address, 6);
        do_dump(8'd4, 9'd3, 32'hA, 4'b1111, 5);

        do_load(8'd16, 9'd8, 32'h100, 3);
        do_dump(8'd16, 9'd8, 32'h100, 4'b1001, -1);

        do_load(8'd254, 9'd4, 32'h50, -1);
        do_dump(8'd254, 9'd4, 32'h50, 4'b1111, 6);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 8'd9; cmd_len = 9'd0; s_valid = 1'b1;
        #1 chk("len0_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("len0_done", done, 1);
        chk("len0_wen", ram_write_en, 0);
        chk("len0_s_ready", s_ready, 0);
        chk("len0_m_valid", m_valid, 0);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("len0_idle_done", done, 0);
        chk("len0_idle_ready", cmd_ready, 1);

        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 8'd16; cmd_len = 9'd8; m_ready = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("midrst_valid_before", m_valid, 1);
        chk("midrst_head_before", m_data, 32'h100);
        reset = 1'b1;
        #1;
        chk("midrst_ready_in_rst", cmd_ready, 0);
        chk("midrst_wen_in_rst", ram_write_en, 0);
        chk("midrst_done_in_rst", done, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_done", done, 0);
        @(negedge clk);
        #1;
        chk("midrst_no_late_done", done, 0);
        do_dump(8'd16, 9'd8, 32'h100, 4'b1111, 10);

        do_load(8'd128, 9'd256, 32'h1000, -1);
        do_dump(8'd128, 9'd256, 32'h1000, 4'b1111, 258);

`ifdef RAM_SEQ_CHECKSUM_EN
        do_load(8'd40, 9'd3, 32'h1, -1);
        chk("checksum_load", checksum, 6);
        do_dump(8'd40, 9'd3, 32'h1, 4'b1111, 5);
        chk("checksum_dump", checksum, 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_seq_master.md
Name: ram_seq_master

Overview:
- Initiator-side sequencer for the team's single-port synchronous RAM (registered read, 1-cycle latency, write-enable strobe).
- Converts block commands into RAM address/write sequences. LOAD moves an input valid/ready stream into RAM; DUMP reads RAM out to an output valid/ready stream with full backpressure.
- Sits between the matrix multiplier datapath and each operand/result RAM instance.

Parameters:
- MEM_DEPTH, 256, number of RAM words; address width AW = $clog2(MEM_DEPTH).
- MEM_WIDTH, 32, data word width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = LOAD (stream to RAM), 0 = DUMP (RAM to stream).
- cmd_base  in  AW  start address.
- cmd_len  in  AW+1  word count, 0..MEM_DEPTH.
- s_valid  in  1  LOAD input word valid.
- s_ready  out  1  LOAD input accept.
- s_data  in  MEM_WIDTH  LOAD input word.
- m_valid  out  1  DUMP output word valid.
- m_ready  in  1  DUMP output accept.
- m_data  out  MEM_WIDTH  DUMP output word.
- done  out  1  one-cycle pulse when a command completes.
- busy  out  1  high whenever not in IDLE.
- ram_address  out  AW  RAM address.
- ram_write_data  out  MEM_WIDTH  RAM write data.
- ram_write_en  out  1  RAM write strobe.
- ram_read_data  in  MEM_WIDTH  RAM registered read data; valid the cycle after ram_address is presented.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - Reset values: cmd_ready=0 during the reset cycle, then 1. s_ready=0, m_valid=0, m_data=0, done=0, busy=0, ram_address=0, ram_write_data=0, ram_write_en=0.
- States: IDLE, LOAD, DUMP, FINISH.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch base and len; set addr=base, remaining=len.
  - len=0 -> FINISH, no RAM access.
  - Otherwise cmd_write=1 -> LOAD, cmd_write=0 -> DUMP.
- LOAD:
  - s_ready=1 combinationally.
  - Each s_valid&s_ready cycle drives a combinational write that cycle: ram_write_en=1, ram_address=addr, ram_write_data=s_data.
  - After each write: addr increments, remaining decrements.
  - Last word written -> FINISH.
  - No write when s_valid=0.
- DUMP:
  - Read is issued (ram_address=addr) only when (words buffered + read in flight) < 2.
  - Returning ram_read_data is captured the following cycle into a 2-entry output FIFO.
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - Pop on m_valid&m_ready.
  - Leave for FINISH when all len words are issued, nothing is in flight, and the FIFO is empty.
  - Throughput is 1 word/cycle with m_ready held high.
  - First m_valid appears 2 cycles after command accept.
  - No word is lost or duplicated under arbitrary m_ready toggling.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Address wrap: addr increments modulo MEM_DEPTH (base=MEM_DEPTH-1 continues at 0).
- len=MEM_DEPTH is legal and touches every word once.
- Command handling: commands offered while busy are not accepted (cmd_ready=0).
- Reset mid-operation: next edge returns to IDLE; FIFO and in-flight flag are flushed; ram_write_en=0 that cycle; no done pulse.
- ram_write_en is never asserted in DUMP; no read-issue logic acts in LOAD.
- ram_address holds its last value when idle.

Optional Feature:
- Macro: RAM_SEQ_CHECKSUM_EN.
- When defined:
  - Adds output checksum [MEM_WIDTH-1:0].
  - Modulo-2^MEM_WIDTH sum of every word transferred (s handshakes in LOAD, m handshakes in DUMP).
  - Cleared on command accept and on reset.
  - Stable from the done pulse until the next command is accepted.
- When undefined: no port, no adder; all other behaviour identical.

Test Plan:
- LOAD base=4 len=3, s_data 0xA,0xB,0xC with s_valid held high -> writes at addr 4,5,6 on three consecutive cycles; done pulses in the 4th cycle after accept.
- DUMP base=4 len=3, m_ready=1 after the prior LOAD -> m_data 0xA,0xB,0xC on consecutive cycles, first 2 cycles after accept; done follows the last pop.
- DUMP len=8 with m_ready toggling 1,0,0,1,… -> all 8 words emitted in order exactly once; never more than 2 reads outstanding/buffered.
- LOAD base=254 len=4 (MEM_DEPTH=256) -> writes to 254,255,0,1; DUMP base=254 len=4 returns them in order.
- cmd len=0 -> done one cycle after accept; ram_write_en stays 0; m_valid stays 0.
- Assert reset mid-DUMP with 2 words buffered -> next cycle m_valid=0, busy=0, cmd_ready=1, no done. With RAM_SEQ_CHECKSUM_EN, LOAD 1,2,3 -> checksum=6 at done.
